// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and helpers for the bit-serial adder.
//   state_t       controller state encoding (IDLE, RUN)
//   cnt_width()   bit-counter width for a given operand width
package serial_add_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter only has to reach WIDTH-1; WIDTH>=2 keeps this at least 1 bit.
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/serial_add_full_add.sv
// full_add: single-bit combinational full adder cell.
//   a, b, cin : addend bits and carry-in
//   s, co     : sum bit and carry-out
// Port shape matches the subtractor cell so the serial controller can host
// either one.
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add.sv
// serial_add: bit-serial ripple adder, LSB first, one bit per clock.
//   clk, rst     : clock, synchronous active-high reset
//   start        : request, taken only while idle
//   a, b, cin    : operands and carry-in, captured when start is accepted
//   busy         : high while bits are being processed
//   done         : one-cycle pulse; sum/cout valid from this cycle on
//   sum, cout    : result registers, updated only on completion or reset
// One result every WIDTH+1 cycles with start held high.
module serial_add
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ra, rb, rs;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             s_bit, c_nxt;
    logic             last;

    full_add u_fa (
        .a   (ra[0]),
        .b   (rb[0]),
        .cin (carry),
        .s   (s_bit),
        .co  (c_nxt)
    );

    assign last = (cnt == LAST);
    // Derived from the state register only, so no input-to-output path.
    assign busy = (state == RUN);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ra    <= '0;
            rb    <= '0;
            rs    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ra    <= a;
                        rb    <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    carry <= c_nxt;
                    ra    <= ra >> 1;
                    rb    <= rb >> 1;
                    rs    <= {s_bit, rs[WIDTH-1:1]};
                    cnt   <= cnt + 1'b1;
                    // Final bit goes straight into sum so the partial rs is
                    // never exposed on the outputs.
                    if (last) begin
                        sum  <= {s_bit, rs[WIDTH-1:1]};
                        cout <= c_nxt;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add.sv
// tb_serial_add: directed and random checks of serial_add at WIDTH=8.
module tb_serial_add;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int n_tests = 0;
    int n_fail  = 0;

    serial_add #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1ns later, away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait up to max edges for done; lat=0 means it never came.
    task automatic wait_done(input int max, output int lat);
        int i;
        lat = 0;
        i   = 0;
        while (i < max && lat == 0) begin
            i++;
            tick();
            if (done) lat = i;
        end
    endtask

    // Full operation: latency, busy span, result, sum stability, done width.
    task automatic op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                      input logic tc, input logic [W-1:0] es, input logic ec);
        logic [W-1:0] prev;
        int           lat, busy_n, i;
        logic         moved;
        prev   = sum;
        busy_n = 0;
        moved  = 1'b0;
        lat    = 0;
        a = ta; b = tb; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        if (busy) busy_n++;
        i = 0;
        while (i < W + 3 && lat == 0) begin
            i++;
            tick();
            if (done) lat = i;
            else begin
                if (busy) busy_n++;
                if (sum !== prev) moved = 1'b1;
            end
        end
        chk({tag, ".lat"}, lat, W);
        chk({tag, ".busy"}, busy_n, W);
        chk({tag, ".stable"}, moved, 0);
        chk({tag, ".sum"}, sum, es);
        chk({tag, ".cout"}, cout, ec);
        tick();
        chk({tag, ".done_low"}, done, 0);
    endtask

    initial begin
        int           lat, extra;
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   ref_v;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.sum",  sum,  0);
        chk("rst.cout", cout, 0);

        op("t3c0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0);
        op("tff01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        op("tffff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

        // Start while busy must be ignored.
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        a = 8'hAA; b = 8'h55; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(W + 3, lat);
        chk("ign.lat", lat, W - 3);
        chk("ign.sum", sum, 8'h46);
        chk("ign.cout", cout, 0);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) extra++;
        end
        chk("ign.no2nd", extra, 0);

        // Reset in the middle of a run discards it.
        a = 8'h80; b = 8'h80; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.sum",  sum,  0);
        chk("abort.cout", cout, 0);
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) extra++;
        end
        chk("abort.nodone", extra, 0);

        // start held high, new operands presented in each done cycle.
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        tick();
        wait_done(W + 3, lat);
        chk("b2b.lat1", lat, W);
        chk("b2b.sum1", sum, 8'h02);
        chk("b2b.cout1", cout, 0);
        a = 8'h7F; b = 8'h01;
        wait_done(W + 4, lat);
        start = 1'b0;
        chk("b2b.gap", lat, W + 1);
        chk("b2b.sum2", sum, 8'h80);
        chk("b2b.cout2", cout, 0);
        tick();
        chk("b2b.done_low", done, 0);
        chk("b2b.idle", busy, 0);

        // Random operations against the a+b+cin reference.
        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            ref_v = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            op("rand", ra, rb, rc, ref_v[W-1:0], ref_v[W]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
